// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter for N_REQ masters.
// One-hot FSM: grant, wait for ready, hold, turnaround.
module bus_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 16,
   parameter int WAIT_TO  = 8,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             bus_rdy,
   output logic [N_REQ-1:0] gnt,
   output logic [3:0]       state_o,
   output logic [2:0]       owner,
   output logic             busy,
   output logic             err
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      BBUSY = 4'b0010,
      BWAIT = 4'b0100,
      BFRER = 4'b1000
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TO - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [2:0]       OWN_RST   = 3'(N_REQ - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [N_REQ-1:0] gnt_nx;
   logic [2:0]       owner_nx;
   logic             busy_nx;
   logic             err_nx;

   logic [N_REQ-1:0] own_oh;
   logic [N_REQ-1:0] win_oh;
   logic             own_req;
   logic             oth_req;
   logic             win_vld;
   logic [2:0]       win;
   int               idx;

   // decode the current owner index into a one-hot mask
   always_comb begin
      own_oh = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (owner == 3'(j)) begin
            own_oh[j] = 1'b1;
         end
      end
   end

   assign own_req = |(req & own_oh);
   assign oth_req = |(req & ~own_oh);

   // rotating scan: owner+1 first, owner itself last
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(owner) + i) % N_REQ;
         for (int j = 0; j < N_REQ; j++) begin
            if (!win_vld && j == idx && req[j]) begin
               win     = 3'(j);
               win_vld = 1'b1;
            end
         end
      end
   end

   // one-hot image of the scan winner
   always_comb begin
      win_oh = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (win == 3'(j)) begin
            win_oh[j] = 1'b1;
         end
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      gnt_nx   = gnt;
      owner_nx = owner;
      err_nx   = 1'b0;
      unique case (1'b1)
         state[0]: begin
            cnt_nx = '0;
            gnt_nx = '0;
            if (win_vld) begin
               state_nx = BWAIT;
               owner_nx = win;
               gnt_nx   = win_oh;
            end
         end
         state[2]: begin
            if (!own_req) begin
               state_nx = BFRER;
               gnt_nx   = '0;
               cnt_nx   = '0;
            end else if (bus_rdy) begin
               state_nx = BBUSY;
               cnt_nx   = '0;
            end else if (cnt == WAIT_LAST) begin
               state_nx = BFRER;
               gnt_nx   = '0;
               cnt_nx   = '0;
               err_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         state[1]: begin
            if (!own_req || (cnt == HOLD_LAST && oth_req)) begin
               state_nx = BFRER;
               gnt_nx   = '0;
               cnt_nx   = '0;
            end else if (cnt != HOLD_LAST) begin
               cnt_nx = cnt + 1'b1;
            end
         end
         state[3]: begin
            state_nx = IDLE;
            gnt_nx   = '0;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
            cnt_nx   = '0;
         end
      endcase
      busy_nx = (state_nx == BWAIT) || (state_nx == BBUSY);
   end

   // state and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         gnt   <= '0;
         owner <= OWN_RST;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         gnt   <= gnt_nx;
         owner <= owner_nx;
         busy  <= busy_nx;
         err   <= err_nx;
      end
   end

   assign state_o = state;

endmodule
